// File: rtl/lift_seq_ctrl.sv
`timescale 1ns/1ps
// lift_seq_ctrl
// Sequencer for the small/big lift pipeline over one full polynomial.
// A go pulse latches the lift mode, then one start per coefficient is
// issued to the lift core no faster than every II cycles and never with
// more than MAX_INFLIGHT coefficients outstanding. Source and destination
// RAM addresses are formed from the coefficient indices and the residue
// addresses supplied by the core. Coefficients retire in order and done
// pulses once every result row has been written.
//
// Optional build macro: LIFT_SEQ_CTRL_PERF_EN adds the perf_cycles and
// perf_stall counters and their output ports.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   go             one-cycle request to process a polynomial (ignored while busy)
//   mode_in        0 = small lift (6 in, 7 out), 1 = big lift (7 in, 6 out)
//   busy           high from the cycle after an accepted go until done
//   done           one-cycle pulse after the last coefficient retires
//   lift_mode      latched mode driven to the lift core
//   lift_start     one-cycle start pulse to the lift core
//   lift_rd_addr   residue read address from the lift core
//   src_addr       {issue_idx, lift_rd_addr}
//   lift_res_we    result write enable from the lift core
//   lift_res_addr  result residue address from the lift core
//   dst_addr       {retire_idx, lift_res_addr}
//   dst_we         lift_res_we gated by busy
//   perf_cycles    (perf build) busy cycles of the current/last run
//   perf_stall     (perf build) cycles held in ISSUE at the in-flight limit
module lift_seq_ctrl #(
  parameter int N_COEFF      = 4096,
  parameter int IDX_W        = 12,
  parameter int II           = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             mode_in,
  output logic             busy,
  output logic             done,
  output logic             lift_mode,
  output logic             lift_start,
  input  logic [2:0]       lift_rd_addr,
  output logic [IDX_W+2:0] src_addr,
  input  logic             lift_res_we,
  input  logic [2:0]       lift_res_addr,
  output logic [IDX_W+2:0] dst_addr,
  output logic             dst_we
`ifdef LIFT_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stall
`endif
);

  localparam int                 CNT_W   = $clog2(II + 1);
  localparam logic [CNT_W-1:0]   II_LOAD = CNT_W'(II - 1);
  localparam logic [CNT_W-1:0]   II_LAST = CNT_W'(1);
  localparam logic [IDX_W:0]     N_FULL  = (IDX_W + 1)'(N_COEFF);
  localparam logic [3:0]         MAX_IF  = 4'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] ii_cnt;
  logic [CNT_W-1:0] ii_cnt_nx;
  logic             start_nx;
  logic             accept;
  logic             issue_ok;
  logic             retire_evt;
  logic [2:0]       last_res;
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] retire_idx;
  logic [IDX_W:0]   issued;
  logic [IDX_W:0]   retired;
  logic [3:0]       inflight;

  // busy covers the working states only; FIN already reads as not busy so
  // done and the falling edge of busy coincide.
  assign busy     = (state == S_ISSUE) || (state == S_GAP) || (state == S_DRAIN);
  assign done     = (state == S_FIN);
  assign accept   = (state == S_IDLE) && go;
  assign issue_ok = (state == S_ISSUE) && (inflight < MAX_IF);

  // The final result residue of a coefficient marks its retirement; a
  // retire with nothing in flight is a core protocol error and is dropped.
  assign last_res   = lift_mode ? 3'd5 : 3'd6;
  assign retire_evt = busy && lift_res_we && (lift_res_addr == last_res) &&
                      (inflight != 4'd0);

  assign src_addr = {issue_idx, lift_rd_addr};
  assign dst_addr = {retire_idx, lift_res_addr};
  assign dst_we   = lift_res_we & busy;

  // Next-state logic. The GAP counter is loaded with II-1 on issue and the
  // state leaves GAP on the edge where the counter reaches zero, so ISSUE
  // plus the GAP cycles add up to exactly II cycles between starts.
  always_comb begin
    state_nx  = state;
    ii_cnt_nx = ii_cnt;
    start_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ok) begin
          start_nx  = 1'b1;
          ii_cnt_nx = II_LOAD;
          state_nx  = S_GAP;
        end
      end
      S_GAP: begin
        ii_cnt_nx = ii_cnt - II_LAST;
        if (ii_cnt == II_LAST) begin
          state_nx = (issued < N_FULL) ? S_ISSUE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (retired == N_FULL) begin
          state_nx = S_FIN;
        end
      end
      S_FIN: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, start pulse and bookkeeping counters. issue_idx advances on the
  // edge closing each lift_start after the first, so from the first read
  // cycle of coefficient k onward src_addr carries index k. It would wrap
  // after N_COEFF-1, which never happens because issue stops there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ii_cnt     <= '0;
      lift_start <= 1'b0;
      lift_mode  <= 1'b0;
      issue_idx  <= '0;
      retire_idx <= '0;
      issued     <= '0;
      retired    <= '0;
      inflight   <= '0;
    end else begin
      state      <= state_nx;
      ii_cnt     <= ii_cnt_nx;
      lift_start <= start_nx;
      if (accept) begin
        lift_mode  <= mode_in;
        issue_idx  <= '0;
        retire_idx <= '0;
        issued     <= '0;
        retired    <= '0;
        inflight   <= '0;
      end else begin
        if (lift_start) begin
          issued <= issued + 1'b1;
          if (issued != '0) begin
            issue_idx <= issue_idx + 1'b1;
          end
        end
        if (retire_evt) begin
          retire_idx <= retire_idx + 1'b1;
          retired    <= retired + 1'b1;
        end
        case ({lift_start, retire_evt})
          2'b10:   inflight <= inflight + 4'd1;
          2'b01:   inflight <= inflight - 4'd1;
          default: inflight <= inflight;
        endcase
      end
    end
  end

`ifdef LIFT_SEQ_CTRL_PERF_EN
  // Performance counters: both restart on an accepted go and otherwise
  // hold, so the figures of the last run stay readable after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if ((state == S_ISSUE) && (inflight == MAX_IF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lift_seq_ctrl.sv
`timescale 1ns/1ps
// tb_lift_seq_ctrl
// Bench for lift_seq_ctrl with a small polynomial (4 coefficients). Two
// instances share the lift-core model: dut_a allows 4 coefficients in
// flight, dut_b only 2. The model answers each lift_start of the selected
// instance with residue reads and, after a fixed latency, result writes;
// every read and write pushes the address the DUT must present onto a
// scoreboard that is popped in the same cycle.
module tb_lift_seq_ctrl;

  localparam int TN  = 4;
  localparam int TW  = 2;
  localparam int TII = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          go_a;
  logic          go_b;
  logic          mode_in;
  logic [2:0]    lift_rd_addr;
  logic          lift_res_we;
  logic [2:0]    lift_res_addr;

  logic          a_busy, a_done, a_mode, a_start, a_we;
  logic [TW+2:0] a_src, a_dst;
  logic          b_busy, b_done, b_mode, b_start, b_we;
  logic [TW+2:0] b_src, b_dst;

  lift_seq_ctrl #(.N_COEFF(TN), .IDX_W(TW), .II(TII), .MAX_INFLIGHT(4)) dut_a (
    .clk(clk), .rst(rst), .go(go_a), .mode_in(mode_in),
    .busy(a_busy), .done(a_done), .lift_mode(a_mode), .lift_start(a_start),
    .lift_rd_addr(lift_rd_addr), .src_addr(a_src),
    .lift_res_we(lift_res_we), .lift_res_addr(lift_res_addr),
    .dst_addr(a_dst), .dst_we(a_we)
  );

  lift_seq_ctrl #(.N_COEFF(TN), .IDX_W(TW), .II(TII), .MAX_INFLIGHT(2)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .mode_in(mode_in),
    .busy(b_busy), .done(b_done), .lift_mode(b_mode), .lift_start(b_start),
    .lift_rd_addr(lift_rd_addr), .src_addr(b_src),
    .lift_res_we(lift_res_we), .lift_res_addr(lift_res_addr),
    .dst_addr(b_dst), .dst_we(b_we)
  );

  bit            sel;
  logic          s_busy, s_done, s_mode, s_start, s_we;
  logic [TW+2:0] s_src, s_dst;
  assign s_busy  = sel ? b_busy  : a_busy;
  assign s_done  = sel ? b_done  : a_done;
  assign s_mode  = sel ? b_mode  : a_mode;
  assign s_start = sel ? b_start : a_start;
  assign s_we    = sel ? b_we    : a_we;
  assign s_src   = sel ? b_src   : a_src;
  assign s_dst   = sel ? b_dst   : a_dst;

  int total;
  int bad;
  int cyc;
  int lat;
  int go_win;
  bit cur_mode;
  bit manual_we;
  int last_start, last_idx, started, retired_m;
  int done_cnt, done_win, last_wr, first_ret, max_inflight;
  logic busy_at_done;
  int pend_cyc[$];
  int pend_idx[$];
  int start_log[$];
  logic [TW+2:0] exp_dst[$];

  task automatic model_clear();
    pend_cyc.delete();
    pend_idx.delete();
    start_log.delete();
    exp_dst.delete();
    last_start   = -1000;
    last_idx     = 0;
    started      = 0;
    retired_m    = 0;
    done_cnt     = 0;
    done_win     = -1;
    last_wr      = -1;
    first_ret    = -1;
    max_inflight = 0;
    busy_at_done = 1'bx;
  endtask

  // One clock cycle: lift-core model drives its inputs just after the edge,
  // then the scoreboard is checked against the settled DUT outputs.
  task automatic step();
    int n_in, n_out, d, r;
    bit rd_valid;
    logic [TW-1:0] kb;
    logic [2:0] rb;
    logic [TW+2:0] e;
    @(posedge clk);
    #1;
    cyc++;
    n_in  = cur_mode ? 7 : 6;
    n_out = cur_mode ? 6 : 7;
    if (s_start === 1'b1) begin
      start_log.push_back(cyc);
      last_start = cyc;
      last_idx   = started;
      pend_cyc.push_back(cyc);
      pend_idx.push_back(started);
      started++;
    end
    rd_valid      = 1'b0;
    lift_rd_addr  = 3'd0;
    lift_res_we   = 1'b0;
    lift_res_addr = 3'd0;
    d = cyc - last_start;
    if (d >= 1 && d <= n_in) begin
      rd_valid     = 1'b1;
      lift_rd_addr = 3'(d - 1);
    end
    if (pend_cyc.size() > 0 && (cyc - pend_cyc[0]) >= lat) begin
      r  = cyc - pend_cyc[0] - lat;
      kb = TW'(pend_idx[0]);
      rb = 3'(r);
      lift_res_we   = 1'b1;
      lift_res_addr = rb;
      exp_dst.push_back({kb, rb});
      if (r == n_out - 1) begin
        void'(pend_cyc.pop_front());
        void'(pend_idx.pop_front());
        retired_m++;
        last_wr = cyc;
        if (retired_m == 1) first_ret = cyc;
      end
    end
    if (manual_we) begin
      lift_res_we   = 1'b1;
      lift_res_addr = 3'd6;
    end
    if (started - retired_m > max_inflight) max_inflight = started - retired_m;
    #1;
    if (s_done === 1'b1) begin
      done_cnt++;
      done_win     = cyc;
      busy_at_done = s_busy;
    end
    if (rd_valid) begin
      kb = TW'(last_idx);
      e  = {kb, lift_rd_addr};
      total++;
      if (s_src !== e) begin
        bad++;
        $display("[TB] FAIL src_addr @%0d: got %0h want %0h", cyc, s_src, e);
      end
    end
    if (exp_dst.size() > 0) begin
      e = exp_dst.pop_front();
      total++;
      if (s_we !== 1'b1 || s_dst !== e) begin
        bad++;
        $display("[TB] FAIL dst_write @%0d: got we=%b addr=%0h want we=1 addr=%0h",
                 cyc, s_we, s_dst, e);
      end
    end else if (!manual_we) begin
      total++;
      if (s_we !== 1'b0) begin
        bad++;
        $display("[TB] FAIL dst_we_idle @%0d: got %b want 0", cyc, s_we);
      end
    end
  endtask

  task automatic launch(input bit m);
    cur_mode = m;
    mode_in  = m;
    if (sel) go_b = 1'b1;
    else     go_a = 1'b1;
    go_win = cyc;
    step();
    go_a = 1'b0;
    go_b = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    model_clear();
    rst = 1'b1;
    step();
    step();
    total++; if (a_busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", a_busy); end
    total++; if (a_done !== 1'b0)  begin bad++; $display("[TB] FAIL reset_done: got %b want 0", a_done); end
    total++; if (a_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_start: got %b want 0", a_start); end
    total++; if (a_mode !== 1'b0)  begin bad++; $display("[TB] FAIL reset_mode: got %b want 0", a_mode); end
    total++; if (b_busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy_b: got %b want 0", b_busy); end
    total++; if (a_src !== '0)     begin bad++; $display("[TB] FAIL reset_src: got %0h want 0", a_src); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_small_lift();
    $display("[TB] test_small_lift");
    sel = 1'b0; lat = 20; model_clear();
    launch(1'b0);
    total++; if (s_busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_after_go: got %b want 1", s_busy); end
    for (int i = 0; i < 400 && done_cnt == 0; i++) step();
    total++; if (done_cnt == 0) begin bad++; $display("[TB] FAIL small_timeout: got no done want done"); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("[TB] FAIL busy_with_done: got %b want 0", busy_at_done); end
    repeat (10) step();
    total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL small_done_count: got %0d want 1", done_cnt); end
    total++; if (start_log.size() !== TN) begin bad++; $display("[TB] FAIL small_start_count: got %0d want %0d", start_log.size(), TN); end
    for (int i = 0; i < TN && i < start_log.size(); i++) begin
      total++;
      if (start_log[i] !== go_win + 2 + TII * i) begin
        bad++;
        $display("[TB] FAIL start_time[%0d]: got %0d want %0d", i, start_log[i] - go_win, 2 + TII * i);
      end
    end
    total++; if (retired_m !== TN) begin bad++; $display("[TB] FAIL small_retired: got %0d want %0d", retired_m, TN); end
    total++;
    if (done_win - last_wr < 1 || done_win - last_wr > 3) begin
      bad++;
      $display("[TB] FAIL done_after_last_write: got %0d want 1..3", done_win - last_wr);
    end
  endtask

  task automatic test_big_lift();
    $display("[TB] test_big_lift");
    sel = 1'b0; lat = 20; model_clear();
    launch(1'b1);
    total++; if (s_mode !== 1'b1) begin bad++; $display("[TB] FAIL big_lift_mode: got %b want 1", s_mode); end
    for (int i = 0; i < 400 && done_cnt == 0; i++) step();
    total++; if (done_cnt == 0) begin bad++; $display("[TB] FAIL big_timeout: got no done want done"); end
    repeat (5) step();
    total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL big_done_count: got %0d want 1", done_cnt); end
    total++; if (start_log.size() !== TN) begin bad++; $display("[TB] FAIL big_start_count: got %0d want %0d", start_log.size(), TN); end
    total++; if (exp_dst.size() !== 0) begin bad++; $display("[TB] FAIL big_scoreboard_left: got %0d want 0", exp_dst.size()); end
  endtask

  task automatic test_inflight_limit();
    $display("[TB] test_inflight_limit");
    sel = 1'b1; lat = 40; model_clear();
    launch(1'b0);
    for (int i = 0; i < 600 && done_cnt == 0; i++) step();
    total++; if (done_cnt == 0) begin bad++; $display("[TB] FAIL limit_timeout: got no done want done"); end
    repeat (5) step();
    total++; if (start_log.size() !== TN) begin bad++; $display("[TB] FAIL limit_start_count: got %0d want %0d", start_log.size(), TN); end
    total++; if (max_inflight > 2) begin bad++; $display("[TB] FAIL limit_max_inflight: got %0d want <=2", max_inflight); end
    if (start_log.size() >= 3) begin
      total++;
      if (start_log[1] !== go_win + 2 + TII) begin
        bad++;
        $display("[TB] FAIL limit_second_start: got %0d want %0d", start_log[1] - go_win, 2 + TII);
      end
      total++;
      if (start_log[2] !== first_ret + 2) begin
        bad++;
        $display("[TB] FAIL limit_third_start: got %0d want %0d", start_log[2], first_ret + 2);
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL limit_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_go_during_busy();
    $display("[TB] test_go_during_busy");
    sel = 1'b0; lat = 20; model_clear();
    launch(1'b0);
    repeat (5) step();
    go_a    = 1'b1;
    mode_in = 1'b1;
    step();
    total++; if (s_mode !== 1'b0) begin bad++; $display("[TB] FAIL mode_kept: got %b want 0", s_mode); end
    // go stays high through the rest of the run, including the FIN cycle
    for (int i = 0; i < 400 && done_cnt == 0; i++) step();
    total++; if (done_cnt == 0) begin bad++; $display("[TB] FAIL busy_go_timeout: got no done want done"); end
    step();
    go_a = 1'b0;
    repeat (10) step();
    total++; if (s_busy !== 1'b0) begin bad++; $display("[TB] FAIL no_restart_busy: got %b want 0", s_busy); end
    total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL busy_go_done_count: got %0d want 1", done_cnt); end
    total++; if (start_log.size() !== TN) begin bad++; $display("[TB] FAIL busy_go_starts: got %0d want %0d", start_log.size(), TN); end
    total++; if (s_mode !== 1'b0) begin bad++; $display("[TB] FAIL mode_after_run: got %b want 0", s_mode); end
  endtask

  task automatic test_reset_mid_run();
    $display("[TB] test_reset_mid_run");
    sel = 1'b0; lat = 20; model_clear();
    mode_in = 1'b0;
    launch(1'b0);
    for (int i = 0; i < 100 && start_log.size() < 2; i++) step();
    total++; if (start_log.size() !== 2) begin bad++; $display("[TB] FAIL mid_two_starts: got %0d want 2", start_log.size()); end
    repeat (3) step();
    rst = 1'b1;
    model_clear();
    step();
    total++; if (s_busy !== 1'b0)  begin bad++; $display("[TB] FAIL mid_rst_busy: got %b want 0", s_busy); end
    total++; if (s_start !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_start: got %b want 0", s_start); end
    total++; if (s_src !== '0)     begin bad++; $display("[TB] FAIL mid_rst_src: got %0h want 0", s_src); end
    total++; if (s_dst !== '0)     begin bad++; $display("[TB] FAIL mid_rst_dst: got %0h want 0", s_dst); end
    rst = 1'b0;
    repeat (3) step();
    total++; if (done_cnt !== 0) begin bad++; $display("[TB] FAIL mid_rst_done: got %0d want 0", done_cnt); end
    launch(1'b0);
    for (int i = 0; i < 400 && done_cnt == 0; i++) step();
    repeat (3) step();
    total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL restart_done_count: got %0d want 1", done_cnt); end
    total++;
    if (start_log.size() < 1 || start_log[0] !== go_win + 2) begin
      bad++;
      $display("[TB] FAIL restart_first_start: got %0d want %0d",
               (start_log.size() > 0) ? start_log[0] - go_win : -1, 2);
    end
  endtask

  task automatic test_spurious_write();
    $display("[TB] test_spurious_write");
    sel = 1'b0; lat = 20; model_clear();
    manual_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (s_we !== 1'b0)   begin bad++; $display("[TB] FAIL spurious_dst_we: got %b want 0", s_we); end
      total++; if (s_busy !== 1'b0) begin bad++; $display("[TB] FAIL spurious_busy: got %b want 0", s_busy); end
    end
    manual_we = 1'b0;
    step();
    total++; if (done_cnt !== 0) begin bad++; $display("[TB] FAIL spurious_done: got %0d want 0", done_cnt); end
    launch(1'b1);
    for (int i = 0; i < 400 && done_cnt == 0; i++) step();
    repeat (3) step();
    total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL post_spurious_done: got %0d want 1", done_cnt); end
    total++; if (retired_m !== TN) begin bad++; $display("[TB] FAIL post_spurious_retired: got %0d want %0d", retired_m, TN); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    sel = 1'b0; lat = 20; cur_mode = 1'b0; manual_we = 1'b0;
    rst = 1'b1; go_a = 1'b0; go_b = 1'b0; mode_in = 1'b0;
    lift_rd_addr = 3'd0; lift_res_we = 1'b0; lift_res_addr = 3'd0;
    test_reset();
    test_small_lift();
    test_big_lift();
    test_inflight_limit();
    test_go_during_busy();
    test_reset_mid_run();
    test_spurious_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
